// File: rtl/dmem_readback.sv
// Streams a window of the data RAM out over valid/ready after the control unit finishes.
// Reads are issued against a credit of free FIFO slots, so back-pressure never drops a byte.
module dmem_readback #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              rd_done
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [ADDR_W:0]   issue_left_reg, issue_left_next;
   logic [ADDR_W:0]   send_left_reg, send_left_next;
   logic              zero_done_reg, zero_done_next;

   logic [RD_LAT-1:0] pipe_reg, pipe_next;
   logic [CNT_W-1:0]  inflight;

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  fifo_count_reg, fifo_count_next;

   logic issue;
   logic push;
   logic pop;
   logic fifo_empty;
   logic fifo_full;
   logic credit_ok;

   // Issue-flag delay line: a flag leaving the last stage marks mem_rdata as valid.
   genvar gi;
   generate
      for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
         if (gi == 0) begin : g_head
            assign pipe_next[gi] = issue;
         end else begin : g_tail
            assign pipe_next[gi] = pipe_reg[gi-1];
         end
      end
   endgenerate

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CNT_W'(pipe_reg[i]);
      end
   end

   assign push       = pipe_reg[RD_LAT-1];
   assign fifo_empty = (fifo_count_reg == '0);
   assign fifo_full  = (fifo_count_reg == CNT_W'(FIFO_DEPTH));
   assign pop        = !fifo_empty && out_ready;
   // Reads already in flight hold a slot, so the FIFO can always absorb them.
   assign credit_ok  = (fifo_count_reg + inflight) < CNT_W'(FIFO_DEPTH);

   always_comb begin
      state_next      = state_reg;
      addr_next       = addr_reg;
      issue_left_next = issue_left_reg;
      send_left_next  = send_left_reg;
      zero_done_next  = 1'b0;
      issue           = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  addr_next       = base_addr;
                  issue_left_next = length;
                  send_left_next  = length;
                  state_next      = S_ISSUE;
               end else begin
                  zero_done_next = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (issue_left_reg == '0) begin
               state_next = S_DRAIN;
            end else if (credit_ok) begin
               issue           = 1'b1;
               addr_next       = addr_reg + 1'b1;
               issue_left_next = issue_left_reg - 1'b1;
               if (issue_left_reg == (ADDR_W+1)'(1)) begin
                  state_next = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop && send_left_reg == (ADDR_W+1)'(1)) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      if ((state_reg == S_ISSUE || state_reg == S_DRAIN) && pop && send_left_reg != '0) begin
         send_left_next = send_left_reg - 1'b1;
      end
   end

   always_comb begin
      fifo_count_next = fifo_count_reg;
      case ({push, pop})
         2'b10:   fifo_count_next = fifo_count_reg + 1'b1;
         2'b01:   fifo_count_next = fifo_count_reg - 1'b1;
         default: fifo_count_next = fifo_count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         addr_reg       <= '0;
         issue_left_reg <= '0;
         send_left_reg  <= '0;
         zero_done_reg  <= 1'b0;
         pipe_reg       <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         addr_reg       <= addr_next;
         issue_left_reg <= issue_left_next;
         send_left_reg  <= send_left_next;
         zero_done_reg  <= zero_done_next;
         pipe_reg       <= pipe_next;
         fifo_count_reg <= fifo_count_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   // Storage needs no reset; the cleared pointers and count make old contents unreachable.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= mem_rdata;
      end
   end

   assign mem_en    = issue;
   assign mem_addr  = addr_reg;
   assign out_valid = !fifo_empty;
   assign out_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
   assign out_last  = !fifo_empty && (send_left_reg == (ADDR_W+1)'(1));
   assign busy      = (state_reg == S_ISSUE) || (state_reg == S_DRAIN);
   assign rd_done   = (state_reg == S_DONE) || zero_done_reg;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule
